// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request channel
// and a valid/ready response channel, with a fixed request-to-response latency.
//
// Ports
//   clk_i         : clock, all state updates on the rising edge
//   reset_i       : synchronous active-low reset
//   req_valid_i   : request presented
//   req_ready_o   : block can accept a request this cycle (IDLE only)
//   req_addr_i    : byte address, word index = req_addr_i[31:2]
//   req_wr_i      : 1 = write, 0 = read
//   req_wdata_i   : write data
//   req_be_i      : byte enables for writes, bit i covers bits [8i+7:8i]
//   resp_valid_o  : response presented (RESP only)
//   resp_ready_i  : initiator accepts the response
//   resp_rdata_o  : read data, 0 for writes, errors and when no response
//   resp_err_o    : misaligned or out-of-range request
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,  // power of two, 2..65536
  parameter int unsigned LATENCY     = 2      // 1..15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Acceptance is blocked during reset so storage cannot change while reset_i = 0.
  logic          accept;
  logic [AW-1:0] idx;
  logic          req_ok;

  assign accept = (state_q == IDLE) && req_valid_i && reset_i;
  assign idx    = req_addr_i[AW+1:2];
  // In range iff every address bit above the word index is zero.
  assign req_ok = (req_addr_i[31:AW+2] == '0) && (req_addr_i[1:0] == 2'b00);

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = resp_valid_o ? rdata_q : 32'h0;
  assign resp_err_o   = resp_valid_o && err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Counter holds the number of WAIT cycles still to spend.
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: storage and response capture registers carry no reset; the memory
  // must survive reset, and the captured response is masked outside RESP.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      err_q   <= !req_ok;
      rdata_q <= '0;
      if (req_ok) begin
        if (req_wr_i) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be_i[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
          end
        end else begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY = 2 for the
// functional vectors and one at LATENCY = 1 for back-to-back timing.
module tb_mem_responder;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  // LATENCY = 2 instance
  logic        req_valid, req_ready, req_wr, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_be;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wr_i    (req_wr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o  (resp_err)
  );

  // LATENCY = 1 instance, response channel always ready
  logic        req_valid1, req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid1),
    .req_ready_o (req_ready1),
    .req_addr_i  (32'h0000_0010),
    .req_wr_i    (1'b0),
    .req_wdata_i (32'h0),
    .req_be_i    (4'hF),
    .resp_valid_o(resp_valid1),
    .resp_ready_i(1'b1),
    .resp_rdata_o(resp_rdata1),
    .resp_err_o  (resp_err1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request from just after a rising edge; returns just after the
  // acceptance edge with req_valid dropped.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(negedge clk_i);
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk_i);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts cycles after acceptance until resp_valid; returns at the negedge
  // of the first response cycle. lat = 99 if no response within the bound.
  task automatic wait_resp(output int lat);
    int n = 1;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (resp_valid) begin
        lat = n;
        break;
      end
      check("idle_rdata_zero", resp_rdata, 32'h0);
      check("idle_err_zero", 32'(resp_err), 32'd0);
      @(posedge clk_i);
      #1;
      n++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(wr, addr, wdata, be);
    wait_resp(lat);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    finish_resp();
  endtask

  initial begin
    int lat;
    reset_i    = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;

    // Full write, read back, partial-byte write
    txn("wr_full", 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    txn("rd_full", 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    txn("wr_be6", 1'b1, 32'h100, 32'h11223344, 4'h6, 32'h0, 1'b0);
    txn("rd_be6", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDE2233EF, 1'b0);

    // Error cases and no-op write
    txn("wr_misalign", 1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    txn("rd_oor", 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1);
    txn("wr_be0", 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    txn("rd_after_err", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDE2233EF, 1'b0);

    // Last in-range word
    txn("wr_last", 1'b1, 32'hFFC, 32'h12345678, 4'hF, 32'h0, 1'b0);
    txn("rd_last", 1'b0, 32'hFFC, 32'h0, 4'hF, 32'h12345678, 1'b0);

    // Backpressure: response held while a competing write is presented
    issue(1'b0, 32'h100, 32'h0, 4'hF);
    wait_resp(lat);
    check("bp_latency", 32'(lat), 32'd2);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h100;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDE2233EF);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      if (i < 4) @(negedge clk_i);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready = 1'b0;
    @(negedge clk_i);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(resp_valid), 32'd0);
    @(posedge clk_i);
    #1;
    txn("bp_rd_after", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDE2233EF, 1'b0);

    // Reset in WAIT drops the response but keeps the committed write
    issue(1'b1, 32'h200, 32'hCAFEF00D, 4'hF);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rstw_no_valid", 32'(resp_valid), 32'd0);
      check("rstw_ready", 32'(req_ready), 32'd1);
      @(posedge clk_i);
      #1;
    end
    txn("rstw_rd", 1'b0, 32'h200, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

    // LATENCY = 1 back-to-back reads: accept in N, N+2; respond in N+1, N+3
    req_valid1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("l1_ready", 32'(req_ready1), 32'((k % 2) == 0));
      check("l1_valid", 32'(resp_valid1), 32'((k % 2) == 1));
      check("l1_err", 32'(resp_err1), 32'd0);
      @(posedge clk_i);
      #1;
    end
    req_valid1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
